// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three completion sources each queue into a small FIFO,
// and one head per cycle is chosen round-robin and registered onto the broadcast bus.
module cdb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ROB_W  = 4,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_rdy,
  input  logic              in_flush,
  input  logic              in_alu_valid,
  input  logic [ROB_W-1:0]  in_alu_reorder,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_alu_branch,
  input  logic              in_lsb_valid,
  input  logic [ROB_W-1:0]  in_lsb_reorder,
  input  logic [DATA_W-1:0] in_lsb_result,
  input  logic              in_lsb_io_read,
  input  logic              in_st_valid,
  input  logic [ROB_W-1:0]  in_st_reorder,
  output logic              out_alu_full,
  output logic              out_lsb_full,
  output logic              out_st_full,
  output logic              out_cdb_enable,
  output logic [ROB_W-1:0]  out_cdb_reorder,
  output logic [DATA_W-1:0] out_cdb_result,
  output logic [DATA_W-1:0] out_cdb_branch,
  output logic              out_cdb_io_read,
  output logic [1:0]        out_cdb_src
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] branch;
    logic              io_read;
  } entry_t;

  entry_t        mem_q [3][DEPTH];
  logic [PW-1:0] wr_q  [3];
  logic [PW-1:0] rd_q  [3];
  logic [CW-1:0] cnt_q [3];
  logic [1:0]    last_q;

  entry_t     push_data [3];
  logic [2:0] valid, full, nonempty, push, pop;
  logic [2:0] cand;
  logic [1:0] win;
  logic       win_found, do_pop;
  entry_t     head;

  // Unused fields are stored as zero so the broadcast needs no per-source masking.
  always_comb begin
    valid        = {in_st_valid, in_lsb_valid, in_alu_valid};
    push_data[0] = '{rob: in_alu_reorder, result: in_alu_result, branch: in_alu_branch,
                     io_read: 1'b0};
    push_data[1] = '{rob: in_lsb_reorder, result: in_lsb_result, branch: '0,
                     io_read: in_lsb_io_read};
    push_data[2] = '{rob: in_st_reorder, result: '0, branch: '0, io_read: 1'b0};
    full     = '0;
    nonempty = '0;
    push     = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      full[i]     = (cnt_q[i] == CW'(DEPTH));
      nonempty[i] = (cnt_q[i] != '0);
      push[i]     = in_rdy & ~in_flush & valid[i] & ~full[i];
    end
  end

  // Search starts at the source after the last winner.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= 3; k++) begin
      cand = {1'b0, last_q} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!win_found && nonempty[cand[1:0]]) begin
        win_found = 1'b1;
        win       = cand[1:0];
      end
    end
    do_pop = in_rdy & ~in_flush & win_found;
    pop    = '0;
    if (do_pop) pop[win] = 1'b1;
    head = mem_q[win][rd_q[win]];
  end

  always_ff @(posedge in_clk) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (push[i]) mem_q[i][wr_q[i]] <= push_data[i];
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int unsigned i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
      end
      last_q          <= 2'd2;  // "last winner = ST" makes ALU searched first
      out_cdb_enable  <= 1'b0;
      out_cdb_reorder <= '0;
      out_cdb_result  <= '0;
      out_cdb_branch  <= '0;
      out_cdb_io_read <= 1'b0;
      out_cdb_src     <= '0;
    end else if (in_flush) begin
      for (int unsigned i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
      end
      out_cdb_enable <= 1'b0;
    end else if (in_rdy) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (push[i]) wr_q[i] <= wr_q[i] + PW'(1);
        if (pop[i])  rd_q[i] <= rd_q[i] + PW'(1);
        cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
      out_cdb_enable <= do_pop;
      if (do_pop) begin
        last_q          <= win;
        out_cdb_src     <= win;
        out_cdb_reorder <= head.rob;
        out_cdb_result  <= head.result;
        out_cdb_branch  <= head.branch;
        out_cdb_io_read <= head.io_read;
      end
    end
  end

  assign out_alu_full = full[0];
  assign out_lsb_full = full[1];
  assign out_st_full  = full[2];

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, round-robin order, full/drop, flush, reset.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, rdy, flush;
  logic        alu_valid, lsb_valid, st_valid, lsb_io;
  logic [3:0]  alu_rob, lsb_rob, st_rob;
  logic [31:0] alu_res, alu_br, lsb_res;
  logic        alu_full, lsb_full, st_full;
  logic        cdb_en, cdb_io;
  logic [3:0]  cdb_rob;
  logic [31:0] cdb_res, cdb_br;
  logic [1:0]  cdb_src;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.DATA_W(32), .ROB_W(4), .DEPTH(2)) dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_rdy(rdy), .in_flush(flush),
    .in_alu_valid(alu_valid), .in_alu_reorder(alu_rob), .in_alu_result(alu_res),
    .in_alu_branch(alu_br),
    .in_lsb_valid(lsb_valid), .in_lsb_reorder(lsb_rob), .in_lsb_result(lsb_res),
    .in_lsb_io_read(lsb_io),
    .in_st_valid(st_valid), .in_st_reorder(st_rob),
    .out_alu_full(alu_full), .out_lsb_full(lsb_full), .out_st_full(st_full),
    .out_cdb_enable(cdb_en), .out_cdb_reorder(cdb_rob), .out_cdb_result(cdb_res),
    .out_cdb_branch(cdb_br), .out_cdb_io_read(cdb_io), .out_cdb_src(cdb_src)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    lsb_valid = 1'b0;
    st_valid  = 1'b0;
  endtask

  task automatic bus(input string tag, input logic en, input logic [1:0] src,
                     input logic [3:0] rob);
    chk({tag, ".en"}, 64'(cdb_en), 64'(en));
    if (en) begin
      chk({tag, ".src"}, 64'(cdb_src), 64'(src));
      chk({tag, ".rob"}, 64'(cdb_rob), 64'(rob));
    end
  endtask

  task automatic push3(input logic [3:0] ra, input logic [3:0] rl, input logic [3:0] rs);
    alu_valid = 1'b1; alu_rob = ra; alu_res = 32'hA0 + 32'(ra); alu_br = 32'hB0 + 32'(ra);
    lsb_valid = 1'b1; lsb_rob = rl; lsb_res = 32'hC0 + 32'(rl); lsb_io = 1'b0;
    st_valid  = 1'b1; st_rob  = rs;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    idle();
    alu_rob = '0; alu_res = '0; alu_br = '0; lsb_rob = '0; lsb_res = '0; lsb_io = 1'b0;
    st_rob = '0;
    #2;
    bus("reset", 1'b0, 2'd0, 4'd0);
    chk("reset.rob", 64'(cdb_rob), 64'd0);
    chk("reset.src", 64'(cdb_src), 64'd0);
    chk("reset.full", 64'({alu_full, lsb_full, st_full}), 64'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Single ALU completion: two-edge latency, one-cycle pulse.
    alu_valid = 1'b1; alu_rob = 4'd3; alu_res = 32'h11; alu_br = 32'h100;
    tick();
    idle();
    bus("alu1.push_edge", 1'b0, 2'd0, 4'd0);
    tick();
    bus("alu1.bcast", 1'b1, 2'd0, 4'd3);
    chk("alu1.result", 64'(cdb_res), 64'h11);
    chk("alu1.branch", 64'(cdb_br), 64'h100);
    chk("alu1.io", 64'(cdb_io), 64'd0);
    tick();
    bus("alu1.after", 1'b0, 2'd0, 4'd0);

    // Store broadcast carries zero result/branch/io_read.
    st_valid = 1'b1; st_rob = 4'd9;
    tick();
    idle();
    tick();
    bus("st.bcast", 1'b1, 2'd2, 4'd9);
    chk("st.result", 64'(cdb_res), 64'd0);
    chk("st.branch", 64'(cdb_br), 64'd0);
    chk("st.io", 64'(cdb_io), 64'd0);
    tick();
    bus("st.after", 1'b0, 2'd0, 4'd0);

    // Simultaneous triple after an ST win: ALU, LSB, ST order.
    push3(4'd1, 4'd2, 4'd5);
    tick();
    idle();
    bus("tri1.push_edge", 1'b0, 2'd0, 4'd0);
    tick();
    bus("tri1.a", 1'b1, 2'd0, 4'd1);
    chk("tri1.a.result", 64'(cdb_res), 64'hA1);
    chk("tri1.a.branch", 64'(cdb_br), 64'hB1);
    tick();
    bus("tri1.l", 1'b1, 2'd1, 4'd2);
    chk("tri1.l.result", 64'(cdb_res), 64'hC2);
    chk("tri1.l.branch", 64'(cdb_br), 64'd0);
    tick();
    bus("tri1.s", 1'b1, 2'd2, 4'd5);
    chk("tri1.s.result", 64'(cdb_res), 64'd0);
    push3(4'd4, 4'd6, 4'd8);
    tick();
    idle();
    bus("tri2.push_edge", 1'b0, 2'd0, 4'd0);
    tick(); bus("tri2.a", 1'b1, 2'd0, 4'd4);
    tick(); bus("tri2.l", 1'b1, 2'd1, 4'd6);
    tick(); bus("tri2.s", 1'b1, 2'd2, 4'd8);
    tick(); bus("tri2.after", 1'b0, 2'd0, 4'd0);

    // LSB io_read load.
    lsb_valid = 1'b1; lsb_rob = 4'd7; lsb_res = 32'hFF; lsb_io = 1'b1;
    tick();
    idle();
    tick();
    bus("ld.bcast", 1'b1, 2'd1, 4'd7);
    chk("ld.result", 64'(cdb_res), 64'hFF);
    chk("ld.branch", 64'(cdb_br), 64'd0);
    chk("ld.io", 64'(cdb_io), 64'd1);
    tick();
    lsb_io = 1'b0;

    // Fill ALU to DEPTH, stall, then a push while full is dropped.
    push3(4'd1, 4'd2, 4'd3);
    tick();
    alu_rob = 4'd4; alu_res = 32'hA4; lsb_rob = 4'd5; st_valid = 1'b0;
    tick();
    idle();
    bus("full.s1", 1'b1, 2'd2, 4'd3);
    chk("full.alu", 64'(alu_full), 64'd1);
    chk("full.lsb", 64'(lsb_full), 64'd1);
    chk("full.st", 64'(st_full), 64'd0);
    rdy = 1'b0;
    alu_valid = 1'b1; alu_rob = 4'd6;
    tick(); tick();
    bus("stall.hold", 1'b1, 2'd2, 4'd3);
    chk("stall.alu_full", 64'(alu_full), 64'd1);
    rdy = 1'b1;
    tick();
    idle();
    bus("drain.a1", 1'b1, 2'd0, 4'd1);
    chk("drain.alu_full", 64'(alu_full), 64'd0);
    tick(); bus("drain.l1", 1'b1, 2'd1, 4'd2);
    tick(); bus("drain.a2", 1'b1, 2'd0, 4'd4);
    tick(); bus("drain.l2", 1'b1, 2'd1, 4'd5);
    tick(); bus("drain.done", 1'b0, 2'd0, 4'd0);

    // Flush with entries queued; a push during flush is dropped.
    push3(4'd1, 4'd2, 4'd3);
    tick();
    tick();
    idle();
    bus("pre_flush", 1'b1, 2'd2, 4'd3);
    chk("pre_flush.alu_full", 64'(alu_full), 64'd1);
    flush = 1'b1; alu_valid = 1'b1; alu_rob = 4'd9;
    tick();
    flush = 1'b0;
    idle();
    bus("flush.en", 1'b0, 2'd0, 4'd0);
    chk("flush.full", 64'({alu_full, lsb_full, st_full}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      bus("flush.quiet", 1'b0, 2'd0, 4'd0);
    end

    // Asynchronous reset between edges with entries queued.
    alu_valid = 1'b1; alu_rob = 4'd2; lsb_valid = 1'b1; lsb_rob = 4'd3;
    tick();
    idle();
    tick();
    bus("prerst", 1'b1, 2'd0, 4'd2);
    #2;
    rst_n = 1'b0;
    #1;
    bus("arst.en", 1'b0, 2'd0, 4'd0);
    chk("arst.rob", 64'(cdb_rob), 64'd0);
    chk("arst.result", 64'(cdb_res), 64'd0);
    chk("arst.branch", 64'(cdb_br), 64'd0);
    chk("arst.src", 64'(cdb_src), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus("arst.quiet", 1'b0, 2'd0, 4'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
